// File: rtl/dct_pkg.sv
// dct_pkg: FSM state type, default sizing constants and sel-width helper
package dct_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_GRANT, ST_START, ST_WAIT, ST_RELEASE} state_t;
  localparam int DCT_N_REQ = 2;
  localparam int DCT_TIMEOUT = 64;
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dct_rr_pick.sv
// dct_rr_pick: round-robin search starting at last+1, wrapping N_REQ-1 -> 0
module dct_rr_pick import dct_pkg::*; #(
  parameter int N_REQ = DCT_N_REQ,
  localparam int W = sel_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [W-1:0]     last,
  output logic [N_REQ-1:0] gnt,
  output logic [W-1:0]     idx
);
  logic [W-1:0] j;
  // walking the distance downwards leaves the nearest requester in idx
  always_comb begin
    idx = '0;
    j = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      j = W'((int'(last) + i) % N_REQ);
      if (req[j]) idx = j;
    end
    gnt = (|req) ? N_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/dct_core_arbiter.sv
// dct_core_arbiter: round-robin ownership of a shared 1-D DCT core.
// Define DCT_ARB_TIMEOUT_EN to bound the WAIT state to TIMEOUT cycles.
module dct_core_arbiter import dct_pkg::*; #(
  parameter int N_REQ = DCT_N_REQ,
  parameter int TIMEOUT = DCT_TIMEOUT,
  localparam int W = sel_w(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [W-1:0]     sel,
  output logic             core_start,
  input  logic             core_done,
  output logic [N_REQ-1:0] req_done,
  output logic             busy,
  output logic             stray_done,
  output logic             timeout
);
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("dct_core_arbiter: unsupported N_REQ or TIMEOUT");
  end
  state_t state_q, state_d;
  logic [W-1:0] owner_q, owner_d, last_q, last_d, sel_q, sel_d, pick_idx;
  logic [N_REQ-1:0] gnt_q, gnt_d, req_done_q, req_done_d, pick_gnt;
  logic core_start_q, core_start_d, busy_q, busy_d, stray_q, stray_d, owned, expire;
  dct_rr_pick #(.N_REQ(N_REQ)) u_pick (.req(req), .last(last_q), .gnt(pick_gnt), .idx(pick_idx));
`ifdef DCT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic timeout_q, timeout_d;
  assign expire = cnt_q == CW'(TIMEOUT - 1);
  assign timeout = timeout_q;
`else
  assign expire = 1'b0;
  assign timeout = 1'b0;
`endif
  assign gnt = gnt_q;
  assign sel = sel_q;
  assign core_start = core_start_q;
  assign req_done = req_done_q;
  assign busy = busy_q;
  assign stray_done = stray_q;
  // outputs are decoded from the next state so they register in step with it
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d = last_q;
    unique case (state_q)
      ST_IDLE: if (|pick_gnt) begin state_d = ST_GRANT; owner_d = pick_idx; end
      ST_GRANT: state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT: if (core_done || expire) state_d = ST_RELEASE;
      ST_RELEASE: begin state_d = ST_IDLE; last_d = owner_q; end
      default: state_d = ST_IDLE;
    endcase
    owned = state_d inside {ST_GRANT, ST_START, ST_WAIT};
    gnt_d = owned ? N_REQ'(1) << owner_d : '0;
    sel_d = owned ? owner_d : '0;
    core_start_d = state_d == ST_START;
    req_done_d = (state_d == ST_RELEASE) ? N_REQ'(1) << owner_d : '0;
    busy_d = state_d != ST_IDLE;
    stray_d = stray_q | (core_done & (state_q != ST_WAIT));
`ifdef DCT_ARB_TIMEOUT_EN
    cnt_d = (state_q == ST_WAIT && state_d == ST_WAIT) ? cnt_q + 1'b1 : '0;
    timeout_d = state_q == ST_WAIT && expire && !core_done;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q <= W'(N_REQ - 1);
      gnt_q <= '0;
      sel_q <= '0;
      core_start_q <= 1'b0;
      req_done_q <= '0;
      busy_q <= 1'b0;
      stray_q <= 1'b0;
`ifdef DCT_ARB_TIMEOUT_EN
      cnt_q <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      gnt_q <= gnt_d;
      sel_q <= sel_d;
      core_start_q <= core_start_d;
      req_done_q <= req_done_d;
      busy_q <= busy_d;
      stray_q <= stray_d;
`ifdef DCT_ARB_TIMEOUT_EN
      cnt_q <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
endmodule
